// File: rtl/csr_bank_pkg.sv
// Shared constants for the per-channel CSR bank: register offsets, channel stride
// and the response FSM state type.
package csr_bank_pkg;

   localparam logic [3:0] OFF_CTRL     = 4'h0;
   localparam logic [3:0] OFF_STATUS   = 4'h4;
   localparam logic [3:0] OFF_IRQ_STAT = 4'h8;
   localparam logic [3:0] OFF_IRQ_EN   = 4'hC;

   localparam int unsigned CH_STRIDE = 32'h10;

   typedef enum logic {
      StIdle,
      StResp
   } state_e;

endpackage

// File: rtl/csr_bank_ch.sv
// One channel's register set: CTRL, sticky IRQ_STAT with write-1-to-clear, IRQ_EN
// and the interrupt reduction.
module csr_bank_ch
   import csr_bank_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] CTRL_RST   = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ctrl_we,
   input  logic                  en_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] clr,
   input  logic [DATA_WIDTH-1:0] events,
   output logic [DATA_WIDTH-1:0] ctrl,
   output logic [DATA_WIDTH-1:0] irq_stat,
   output logic [DATA_WIDTH-1:0] irq_en,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] ctrl_q;
   logic [DATA_WIDTH-1:0] stat_q;
   logic [DATA_WIDTH-1:0] en_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctrl_q <= CTRL_RST;
         stat_q <= '0;
         en_q   <= '0;
      end else begin
         if (ctrl_we) ctrl_q <= wdata;
         if (en_we)   en_q   <= wdata;
         // Event ORed in after the clear so a same-cycle pulse is never lost.
         stat_q <= (stat_q & ~clr) | events;
      end
   end

   assign ctrl     = ctrl_q;
   assign irq_stat = stat_q;
   assign irq_en   = en_q;
   assign irq      = |(stat_q & en_q);

endmodule

// File: rtl/csr_bank.sv
// Multi-channel CSR bank behind a valid/ready request/response port with one-cycle
// read latency and back-to-back throughput.
module csr_bank
   import csr_bank_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           NUM_CH     = 4,
   parameter logic [DATA_WIDTH-1:0] CTRL_RST   = '0
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_wen,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   input  logic [DATA_WIDTH-1:0]        req_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_WIDTH-1:0]        rsp_rdata,
   output logic                         rsp_err,
   output logic [NUM_CH*DATA_WIDTH-1:0] ctrl_o,
   input  logic [NUM_CH*DATA_WIDTH-1:0] status_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] event_i,
   output logic [NUM_CH-1:0]            irq_o
);

   state_e                state_q;
   logic [3:0]            off;
   logic [31:0]           ch;
   logic                  ch_ok;
   logic                  err;
   logic                  accept;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] rsp_load;

   logic [DATA_WIDTH-1:0] ctrl_a [NUM_CH];
   logic [DATA_WIDTH-1:0] stat_a [NUM_CH];
   logic [DATA_WIDTH-1:0] en_a   [NUM_CH];

   assign off    = req_addr[3:0];
   assign ch     = 32'(req_addr[ADDR_WIDTH-1:4]);
   assign ch_ok  = ch < NUM_CH;
   assign err    = !ch_ok || (req_addr[1:0] != 2'b00) || (req_wen && off == OFF_STATUS);
   assign accept = req_valid && req_ready;
   assign wr_ok  = accept && req_wen && !err;

   assign req_ready = (state_q == StIdle) || rsp_ready;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic hit;
      assign hit = (ch == 32'(n));

      csr_bank_ch #(
         .DATA_WIDTH (DATA_WIDTH),
         .CTRL_RST   (CTRL_RST)
      ) u_ch (
         .clk      (clk),
         .rstn     (rstn),
         .ctrl_we  (wr_ok && hit && off == OFF_CTRL),
         .en_we    (wr_ok && hit && off == OFF_IRQ_EN),
         .wdata    (req_wdata),
         .clr      ((wr_ok && hit && off == OFF_IRQ_STAT) ? req_wdata : '0),
         .events   (event_i[n*DATA_WIDTH +: DATA_WIDTH]),
         .ctrl     (ctrl_a[n]),
         .irq_stat (stat_a[n]),
         .irq_en   (en_a[n]),
         .irq      (irq_o[n])
      );

      assign ctrl_o[n*DATA_WIDTH +: DATA_WIDTH] = ctrl_a[n];
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
         if (ch == n) begin
            case (off)
               OFF_CTRL:     rd_data = ctrl_a[n];
               OFF_STATUS:   rd_data = status_i[n*DATA_WIDTH +: DATA_WIDTH];
               OFF_IRQ_STAT: rd_data = stat_a[n];
               OFF_IRQ_EN:   rd_data = en_a[n];
               default:      rd_data = '0;
            endcase
         end
      end
   end

   // Sampled from pre-write register values; writes and errors return zero.
   assign rsp_load = (req_wen || err) ? '0 : rd_data;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q   <= StResp;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_load;
                  rsp_err   <= err;
               end
            end
            StResp: begin
               if (accept) begin
                  rsp_rdata <= rsp_load;
                  rsp_err   <= err;
               end else if (rsp_ready) begin
                  state_q   <= StIdle;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: reset, CTRL round trip, IRQ set/clear, error decode,
// response backpressure and reset during a pending response.
module tb_csr_bank;

   localparam logic [31:0] CRST = 32'h0000_1234;

   logic         clk;
   logic         rstn;
   logic         req_valid;
   logic         req_ready;
   logic         req_wen;
   logic [15:0]  req_addr;
   logic [31:0]  req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   logic [127:0] ctrl_o;
   logic [127:0] status_i;
   logic [127:0] event_i;
   logic [3:0]   irq_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]  rd;
   logic         er;
   logic [127:0] ev_b3;

   csr_bank #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (16),
      .NUM_CH     (4),
      .CTRL_RST   (CRST)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ctrl_o    (ctrl_o),
      .status_i  (status_i),
      .event_i   (event_i),
      .irq_o     (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transaction with rsp_ready high; ev is driven on event_i during the request cycle.
   task automatic xact(input logic wen, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [127:0] ev, output logic [31:0] rdata, output logic err);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      event_i   = ev;
      @(negedge clk);
      req_valid = 1'b0;
      req_wen   = 1'b0;
      event_i   = '0;
      check("xact_rsp_valid", {127'd0, rsp_valid}, 128'd1);
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   task automatic pulse(input logic [127:0] ev);
      @(negedge clk);
      event_i = ev;
      @(negedge clk);
      event_i = '0;
   endtask

   initial begin
      rstn      = 1'b0;
      req_valid = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      event_i   = '0;
      status_i  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
      ev_b3     = 128'h8 << 32;

      // Reset state
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      check("rst_ctrl", ctrl_o, {CRST, CRST, CRST, CRST});
      check("rst_irq", {124'd0, irq_o}, 128'd0);
      check("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
      check("rst_req_ready", {127'd0, req_ready}, 128'd1);

      // Back-to-back write then read of ch2 CTRL
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 16'h0020; req_wdata = 32'h0000_00A5;
      @(negedge clk);
      req_wen = 1'b0;
      check("b2b_ctrl2", {96'd0, ctrl_o[95:64]}, 128'hA5);
      check("b2b_wr_valid", {127'd0, rsp_valid}, 128'd1);
      check("b2b_wr_rdata", {96'd0, rsp_rdata}, 128'd0);
      check("b2b_wr_err", {127'd0, rsp_err}, 128'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_rd_valid", {127'd0, rsp_valid}, 128'd1);
      check("b2b_rd_rdata", {96'd0, rsp_rdata}, 128'hA5);
      check("b2b_rd_err", {127'd0, rsp_err}, 128'd0);
      @(negedge clk);
      check("b2b_idle", {127'd0, rsp_valid}, 128'd0);

      // Interrupt set, enable, clear, and event winning over clear
      pulse(ev_b3);
      check("irq_masked", {124'd0, irq_o}, 128'd0);
      xact(1'b1, 16'h001C, 32'h8, '0, rd, er);
      check("irq_en_set", {124'd0, irq_o}, 128'h2);
      xact(1'b0, 16'h0018, 32'h0, '0, rd, er);
      check("irq_stat_rd", {96'd0, rd}, 128'h8);
      xact(1'b0, 16'h001C, 32'h0, '0, rd, er);
      check("irq_en_rd", {96'd0, rd}, 128'h8);
      xact(1'b1, 16'h0018, 32'h8, '0, rd, er);
      check("irq_cleared", {124'd0, irq_o}, 128'h0);
      pulse(ev_b3);
      check("irq_reset", {124'd0, irq_o}, 128'h2);
      xact(1'b1, 16'h0018, 32'h8, ev_b3, rd, er);
      check("irq_ev_wins", {124'd0, irq_o}, 128'h2);
      xact(1'b0, 16'h0018, 32'h0, '0, rd, er);
      check("irq_ev_wins_rd", {96'd0, rd}, 128'h8);
      xact(1'b0, 16'h0034, 32'h0, '0, rd, er);
      check("status_rd", {96'd0, rd}, 128'hCAFE_0003);
      check("status_err", {127'd0, er}, 128'd0);

      // Error decode: no data, no state change
      xact(1'b0, 16'h0040, 32'h0, '0, rd, er);
      check("err_ch_rd", {95'd0, er, rd}, {95'd0, 1'b1, 32'd0});
      xact(1'b0, 16'h0002, 32'h0, '0, rd, er);
      check("err_align_rd", {95'd0, er, rd}, {95'd0, 1'b1, 32'd0});
      xact(1'b1, 16'h0004, 32'hFFFF_FFFF, '0, rd, er);
      check("err_wr_status", {95'd0, er, rd}, {95'd0, 1'b1, 32'd0});
      xact(1'b1, 16'h0040, 32'hDEAD_BEEF, '0, rd, er);
      check("err_ch_wr", {127'd0, er}, 128'd1);
      xact(1'b1, 16'h0021, 32'h77, '0, rd, er);
      check("err_align_wr", {127'd0, er}, 128'd1);
      xact(1'b1, 16'h0019, 32'h8, '0, rd, er);
      check("err_align_w1c", {127'd0, er}, 128'd1);
      check("err_ctrl_kept", ctrl_o, {CRST, 32'hA5, CRST, CRST});
      check("err_irq_kept", {124'd0, irq_o}, 128'h2);

      // Response backpressure with a queued write
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 16'h0020; rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            req_wen = 1'b1; req_addr = 16'h0000; req_wdata = 32'h55;
            #1;
         end
         check("bp_valid", {127'd0, rsp_valid}, 128'd1);
         check("bp_rdata", {96'd0, rsp_rdata}, 128'hA5);
         check("bp_ready", {127'd0, req_ready}, 128'd0);
      end
      check("bp_ctrl0_held", {96'd0, ctrl_o[31:0]}, {96'd0, CRST});
      rsp_ready = 1'b1;
      #1;
      check("bp_ready_rise", {127'd0, req_ready}, 128'd1);
      @(negedge clk);
      req_valid = 1'b0; req_wen = 1'b0;
      check("bp_wr_valid", {127'd0, rsp_valid}, 128'd1);
      check("bp_wr_rdata", {96'd0, rsp_rdata}, 128'd0);
      check("bp_ctrl0", {96'd0, ctrl_o[31:0]}, 128'h55);
      @(negedge clk);
      check("bp_idle", {127'd0, rsp_valid}, 128'd0);

      // Reset while a response is pending
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 16'h0020; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_pending", {127'd0, rsp_valid}, 128'd1);
      #2 rstn = 1'b0;
      #1;
      check("mid_rsp_valid", {127'd0, rsp_valid}, 128'd0);
      check("mid_rsp_rdata", {96'd0, rsp_rdata}, 128'd0);
      check("mid_ctrl", ctrl_o, {CRST, CRST, CRST, CRST});
      check("mid_irq", {124'd0, irq_o}, 128'd0);
      @(negedge clk);
      rstn = 1'b1;
      rsp_ready = 1'b1;
      xact(1'b0, 16'h0020, 32'h0, '0, rd, er);
      check("post_rst_rd", {95'd0, er, rd}, {95'd0, 1'b0, CRST});
      xact(1'b0, 16'h001C, 32'h0, '0, rd, er);
      check("post_rst_en", {96'd0, rd}, 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and bus data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 SHALL have parameter NUM_CH, default 4, channel count (1..16).
REQ-004 SHALL have parameter CTRL_RST, default 0, reset value of every CTRL register.
REQ-005 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-009 SHALL have port req_wen  in  1  1=write, 0=read.
REQ-010 SHALL have port req_addr  in  ADDR_WIDTH  byte address.
REQ-011 SHALL have port req_wdata  in  DATA_WIDTH  write data.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err  out  1  access error flag.
REQ-016 SHALL have port ctrl_o  out  NUM_CH*DATA_WIDTH  CTRL registers, channel n at slice n.
REQ-017 SHALL have port status_i  in  NUM_CH*DATA_WIDTH  hardware status, read-only view.
REQ-018 SHALL have port event_i  in  NUM_CH*DATA_WIDTH  single-cycle event pulses per bit.
REQ-019 SHALL have port irq_o  out  NUM_CH  per-channel interrupt.

Function
REQ-020 SHALL decode the address as ch = req_addr[ADDR_WIDTH-1:4], off = req_addr[3:0]; map: 0x0 CTRL (RW), 0x4 STATUS (RO, returns status_i), 0x8 IRQ_STAT (read, write-1-to-clear), 0xC IRQ_EN (RW).
REQ-021 SHALL flag rsp_err=1 with no state change for: ch >= NUM_CH, req_addr[1:0] != 0, or a write to STATUS.
REQ-022 SHALL implement a two-state FSM: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-023 SHALL drive req_ready = (state==IDLE) | rsp_ready.
REQ-024 SHALL, on accept (req_valid & req_ready), perform any write at that edge and load rsp_rdata/rsp_err from pre-write register values, entering RESP on the next cycle (latency 1).
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready; it SHALL return to IDLE on rsp_ready without a new accept, and stay in RESP with new data on a same-cycle accept (back-to-back, one transaction per cycle).
REQ-026 SHALL update each IRQ_STAT bit every cycle as (stat & ~clr) | event, where clr is the W1C write mask; a same-cycle event SHALL take precedence over the clear.
REQ-027 SHALL drive irq_o[n] = |(IRQ_STAT[n] & IRQ_EN[n]) combinationally from registers.
REQ-028 SHALL ignore req_wen, req_addr and req_wdata when req_valid is low.

Reset
REQ-029 SHALL, on rstn low, set state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, CTRL=CTRL_RST, IRQ_STAT=0, IRQ_EN=0, hence irq_o=0 and ctrl_o=CTRL_RST in every slice.
REQ-030 SHALL discard any pending response on reset mid-transaction; the first request after release SHALL be accepted normally.

Structure
REQ-031 SHALL place offset constants (OFF_CTRL, OFF_STATUS, OFF_IRQ_STAT, OFF_IRQ_EN), channel stride 0x10 and the FSM state enum in package csr_bank_pkg.
REQ-032 SHALL implement the per-channel register set (CTRL, IRQ_STAT, IRQ_EN, irq reduction) as sub-module csr_bank_ch, instantiated NUM_CH times by generate.

Verification
REQ-033 Reset release -> ctrl_o all slices = CTRL_RST, irq_o=0, rsp_valid=0, req_ready=1.
REQ-034 Write 0x0000_00A5 to 0x0020 then read 0x0020, rsp_ready held high -> ctrl_o slice 2 = 0xA5 one cycle after write accept; read rsp_rdata=0xA5, rsp_err=0, two responses in consecutive cycles.
REQ-035 event_i ch1 bit3 pulse, write IRQ_EN 0x0008 to 0x001C -> irq_o[1]=1; write 0x0008 to 0x0018 -> irq_o[1]=0 next cycle; repeat with event pulse in the clear cycle -> bit stays set.
REQ-036 Read 0x0040 (ch 4 with NUM_CH=4), read 0x0002, write 0x0004 -> each rsp_err=1, rsp_rdata=0, no register change.
REQ-037 Read with rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; accepted on cycle rsp_ready rises.
REQ-038 rstn asserted while in RESP -> rsp_valid=0 immediately, all registers at reset values.
